// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned LINE_W         = 128;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned WORDS_PER_LINE = 4;
  localparam int unsigned WCNT_W         = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Word at offset 0 sits in the top bits of the line.
  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [1:0]        off);
    logic [WORD_W-1:0] w;
    case (off)
      2'd0:    w = line[127:96];
      2'd1:    w = line[95:64];
      2'd2:    w = line[63:32];
      default: w = line[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Instruction queue: up to four writes per cycle, one pop, synchronous flush.
module instr_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned QDEPTH = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 i_flush,
  input  logic [WCNT_W-1:0]                    i_wr_cnt,
  input  fetch_entry_t [WORDS_PER_LINE-1:0]    i_wr_data,
  input  logic                                 i_pop,
  output logic                                 o_valid_c,
  output fetch_entry_t                         o_head_c,
  output logic [$clog2(QDEPTH):0]              o_count
);

  localparam int unsigned AW = $clog2(QDEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t    r_mem [QDEPTH];
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic            w_pop;

  assign w_pop = i_pop && (r_count != '0) && !i_flush;

  // Pointers and occupancy; a flush discards any same-cycle write or pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(i_wr_cnt);
      r_rd_ptr <= r_rd_ptr + AW'(w_pop);
      r_count  <= r_count + CW'(i_wr_cnt) - CW'(w_pop);
    end
  end

  // Storage: entry j of the write bundle lands j slots after the write pointer.
  always_ff @(posedge clk) begin
    if (!i_flush) begin
      for (int j = 0; j < WORDS_PER_LINE; j++) begin
        if (WCNT_W'(j) < i_wr_cnt) begin
          r_mem[r_wr_ptr + AW'(j)] <= i_wr_data[j];
        end
      end
    end
  end

  assign o_valid_c = (r_count != '0);
  assign o_head_c  = o_valid_c ? r_mem[r_rd_ptr] : '0;
  assign o_count   = r_count;

endmodule

// File: rtl/i_fetch.sv
// Instruction fetch: line requests to the I-cache, line slicing into the
// instruction queue, and branch/jump redirection.
module i_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 8
) (
  input  logic               clk,
  input  logic               reset,
  output logic [31:0]        Ic_pc_out,
  output logic               Ic_rd_en,
  input  logic [LINE_W-1:0]  Ic_dout,
  input  logic               Ic_dout_valid,
  output logic [31:0]        Instr_out,
  output logic [31:0]        Pc_out,
  output logic               Instr_valid,
  input  logic               Rd_instr,
  input  logic               Jmp_branch_valid,
  input  logic [31:0]        Jmp_branch_address
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;

  fetch_state_e                       r_state;
  logic [31:2]                        r_fetch_pc;
  logic [27:0]                        w_line;
  logic [1:0]                         w_offset;
  logic [WCNT_W-1:0]                  w_need;
  logic [CW-1:0]                      w_count;
  logic                               w_space_ok;
  logic                               w_accept;
  logic [WCNT_W-1:0]                  w_wr_cnt;
  fetch_entry_t [WORDS_PER_LINE-1:0]  w_wr_data;
  fetch_entry_t                       w_head;
  logic                               w_unused;

  assign w_line     = r_fetch_pc[31:4];
  assign w_offset   = r_fetch_pc[3:2];
  assign w_need     = WCNT_W'(WORDS_PER_LINE) - WCNT_W'(w_offset);
  // Admission uses the registered count only, so the queue can never overflow.
  assign w_space_ok = (CW'(QDEPTH) - w_count) >= CW'(w_need);
  assign w_accept   = (r_state == ST_WAIT) && Ic_dout_valid && !Jmp_branch_valid;
  assign w_wr_cnt   = w_accept ? w_need : '0;
  assign w_unused   = ^Jmp_branch_address[1:0];

  // Slice the line from the current offset upward; slots past w_need are ignored.
  always_comb begin
    w_wr_data = '0;
    for (int j = 0; j < WORDS_PER_LINE; j++) begin
      w_wr_data[j].instr = line_word(Ic_dout, w_offset + 2'(j));
      w_wr_data[j].pc    = {w_line, w_offset + 2'(j), 2'b00};
    end
  end

  // Request FSM and fetch PC; redirect overrides every other transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= RESET_PC[31:2];
      Ic_rd_en   <= 1'b0;
      Ic_pc_out  <= RESET_PC & ~32'hF;
    end else if (Jmp_branch_valid) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= Jmp_branch_address[31:2];
      Ic_rd_en   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_space_ok) begin
            r_state   <= ST_WAIT;
            Ic_rd_en  <= 1'b1;
            Ic_pc_out <= {w_line, 4'b0000};
          end
        end
        ST_WAIT: begin
          if (Ic_dout_valid) begin
            r_state    <= ST_IDLE;
            Ic_rd_en   <= 1'b0;
            r_fetch_pc <= {w_line + 28'd1, 2'b00};
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          Ic_rd_en <= 1'b0;
        end
      endcase
    end
  end

  instr_fifo #(
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_flush   (Jmp_branch_valid),
    .i_wr_cnt  (w_wr_cnt),
    .i_wr_data (w_wr_data),
    .i_pop     (Rd_instr),
    .o_valid_c (Instr_valid),
    .o_head_c  (w_head),
    .o_count   (w_count)
  );

  assign Instr_out = w_head.instr;
  assign Pc_out    = w_head.pc;

endmodule

// File: doc/i_fetch.md
# i_fetch

Instruction fetch unit: the requesting side of the instruction cache's line-read interface. It holds the fetch PC, issues line-aligned read requests, captures each returned 128-bit line, splits it into 32-bit instructions tagged with their PCs, and queues them for decode. It also handles redirection from branches and jumps.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; word aligned.
- `QDEPTH`, default 8: instruction queue depth in words; power of two, ≥ 4.
- `clk` input, 1 bit: clock; all state changes on the rising edge.
- `reset` input, 1 bit: asynchronous reset, active high.
- `Ic_pc_out` output, 32 bits: line address sent to the cache (bits 3:0 are always 0).
- `Ic_rd_en` output, 1 bit: read request level to the cache.
- `Ic_dout` input, 128 bits: returned line.
  - Bits 127:96 hold the word at offset 0.
  - Bits 31:0 hold the word at offset 3.
- `Ic_dout_valid` input, 1 bit: `Ic_dout` is valid this cycle.
- `Instr_out` output, 32 bits: instruction at the queue head.
- `Pc_out` output, 32 bits: PC of the queue head.
- `Instr_valid` output, 1 bit: the queue is non-empty.
- `Rd_instr` input, 1 bit: decode pops the head when `Instr_valid` is 1.
- `Jmp_branch_valid` input, 1 bit: redirect strobe.
- `Jmp_branch_address` input, 32 bits: redirect target, word aligned.

## Operation
- State `fetch_pc[31:2]`, reset value `RESET_PC[31:2]`.
  - Line address is `{fetch_pc[31:4], 4'b0}`.
  - Offset is `fetch_pc[3:2]`.
  - `need = 4 - offset`, range 1..4.
- FSM states are IDLE and WAIT. Reset enters IDLE.
- IDLE:
  - If redirect: load the target and stay in IDLE.
  - Else if `QDEPTH - count >= need`: go to WAIT. Use the registered count; a same-cycle pop is not credited.
  - Else stay in IDLE.
- WAIT:
  - `Ic_rd_en` is 1 and `Ic_pc_out` is held stable.
  - If redirect: load the target and go to IDLE. An `Ic_dout_valid` in that same cycle is discarded.
  - Else if `Ic_dout_valid`: write words offset..3 into the queue in ascending order, with PCs `{line, offset*4}` upward. Then set `fetch_pc` to line+16 (offset 0) and go to IDLE.
  - Else stay in WAIT.
- Queue:
  - FIFO of {pc, instr}.
  - Writes 1–4 words per cycle; pops at most 1 per cycle.
  - `count_next = count + nwrite - pop`.
  - Write and pop in the same cycle are legal.
  - Overflow is impossible by the admission rule above.
- Redirect has priority over everything:
  - The queue is flushed, `count` becomes 0, and any same-cycle pop or write is ignored.
  - `fetch_pc` is set to `Jmp_branch_address[31:2]`.
- Wrap-around:
  - `fetch_pc` wraps modulo 2^32 (line 0xFFFF_FFF0 is followed by 0).
  - Queue pointers wrap modulo `QDEPTH`.
- When empty, `Instr_out` and `Pc_out` drive 0.
- Reset values: `Ic_rd_en` 0, `Ic_pc_out` = `RESET_PC & ~32'hF`, `Instr_valid` 0, `Instr_out` 0, `Pc_out` 0, `count` 0.
- Reset mid-WAIT drops the request immediately (asynchronous); any later `Ic_dout_valid` is ignored, because the FSM is in IDLE.

## Timing
- `Ic_rd_en` and `Ic_pc_out` are registered (`Ic_rd_en` = state==WAIT). Both rise the cycle after the IDLE→WAIT decision.
- Cache latency is arbitrary. The line is accepted on the first edge with `Ic_rd_en` and `Ic_dout_valid` both 1.
- `Ic_rd_en` falls on the edge after acceptance, giving at least 1 IDLE cycle between requests.
- First instruction is visible (`Instr_valid`=1) the cycle after the accepting edge.
- Head outputs are combinational from queue registers; a pop exposes the next entry the following cycle.
- Minimum first-instruction latency after reset release: 3 cycles with a 1-cycle cache.
  - Edge 1: IDLE→WAIT.
  - Edge 2: accept.
  - Cycle 3: valid.

## Structure
- Package `fetch_pkg` holds:
  - `LINE_W`=128, `WORD_W`=32, `WORDS_PER_LINE`=4.
  - The FSM state enum.
  - Queue entry typedef {pc[31:0], instr[31:0]}.
- Sub-module `instr_fifo`: multi-write (up to 4 entries, with a count input), single-pop FIFO with synchronous flush, parameterised by `QDEPTH`.
- Top level: FSM, PC logic and line slicing.

## Test plan
- Reset, `RESET_PC`=0, cache answers 1 cycle after `Ic_rd_en` with {0,1,2,3}, `Rd_instr`=1 → `Instr_out` 0,1,2,3 with `Pc_out` 0x0,0x4,0x8,0xC; next `Ic_pc_out`=0x10.
- `RESET_PC`=0x8, line {0,1,2,3} → only 2,3 queued with `Pc_out` 0x8,0xC; count peaks at 2.
- `Rd_instr`=0, aligned start → after two lines count=8 and `Ic_rd_en` stays 0.
  - Pop 3 → still no request.
  - 4th pop → `Ic_rd_en` rises the cycle after count reads 4.
- Redirect to 0x44 in WAIT, coincident with `Ic_dout_valid` → queue empty, line dropped.
  - Next `Ic_pc_out`=0x40.
  - Line {10,11,12,13} yields 11,12,13 at `Pc_out` 0x44,0x48,0x4C.
- Reset asserted in WAIT → `Ic_rd_en`=0 and `Instr_valid`=0 without a clock edge.
  - After release, `Ic_pc_out`=`RESET_PC` line.
- count=4, pop and full-line write in the same cycle → count=7; FIFO order preserved across pointer wrap.
